// File: rtl/idct_transpose_buf_pkg.sv
// Shared IDCT constants and block address helpers, also used by the output collector.
package idct_transpose_buf_pkg;

    localparam int SAMPLE_W = 25;
    localparam int BLK_N    = 4;

    typedef logic [3:0] blk_addr_t;

    localparam logic BANK_FILLING = 1'b0;
    localparam logic BANK_FULL    = 1'b1;

    function automatic blk_addr_t rm_addr(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

    // Element k of a column-major scan sits at row k[1:0], column k[3:2].
    function automatic blk_addr_t cm_addr(input blk_addr_t idx);
        return rm_addr(idx[1:0], idx[3:2]);
    endfunction

endpackage

// File: rtl/idct_transpose_buf_if.sv
// Row-pass input stream and column-pass output stream of the transpose buffer.
interface idct_transpose_buf_if
    import idct_transpose_buf_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/idct_transpose_buf_tbuf_bank.sv
// One N*N sample bank: synchronous write, combinational read, cleared by reset.
module tbuf_bank #(
    parameter int WIDTH = 25,
    parameter int N     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [$clog2(N*N)-1:0]      waddr,
    input  logic signed [WIDTH-1:0]     wdata,
    input  logic [$clog2(N*N)-1:0]      raddr,
    output logic signed [WIDTH-1:0]     rdata
);
    logic signed [WIDTH-1:0] mem_q [N*N];
    logic signed [WIDTH-1:0] mem_d [N*N];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N*N; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/idct_transpose_buf.sv
// Ping-pong 4x4 transpose buffer: row-major samples in, column-major samples out.
module idct_transpose_buf
    import idct_transpose_buf_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int N     = BLK_N
) (
    input logic                 clk,
    input logic                 reset,
    idct_transpose_buf_if.slave bus
);
    logic [1:0] full_q, full_d;
    logic       wsel_q, wsel_d;
    logic       rsel_q, rsel_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [3:0] rcnt_q, rcnt_d;

    logic wr_fire, rd_fire, set_full, clr_full;
    logic signed [WIDTH-1:0] rdata [2];

    assign bus.in_ready  = (full_q[wsel_q] == BANK_FILLING);
    assign bus.out_valid = (full_q[rsel_q] == BANK_FULL);
    assign bus.out_last  = bus.out_valid && (rcnt_q == 4'd15);
    assign bus.out_data  = rsel_q ? rdata[1] : rdata[0];

    assign wr_fire  = bus.in_valid && bus.in_ready;
    assign rd_fire  = bus.out_valid && bus.out_ready;
    assign set_full = wr_fire && (wcnt_q == 4'd15);
    assign clr_full = rd_fire && (rcnt_q == 4'd15);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        tbuf_bank #(
            .WIDTH (WIDTH),
            .N     (N)
        ) u_bank (
            .clk   (clk),
            .reset (reset),
            .we    (wr_fire && (wsel_q == 1'(b))),
            .waddr (rm_addr(wcnt_q[3:2], wcnt_q[1:0])),
            .wdata (bus.in_data),
            .raddr (cm_addr(rcnt_q)),
            .rdata (rdata[b])
        );
    end

    // Write and read sides touch different banks, so both flag updates can land together.
    always_comb begin
        full_d = full_q;
        wsel_d = wsel_q;
        rsel_d = rsel_q;
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;
        if (wr_fire) begin
            wcnt_d = wcnt_q + 4'd1;
        end
        if (set_full) begin
            full_d[wsel_q] = BANK_FULL;
            wsel_d         = ~wsel_q;
        end
        if (rd_fire) begin
            rcnt_d = rcnt_q + 4'd1;
        end
        if (clr_full) begin
            full_d[rsel_q] = BANK_FILLING;
            rsel_d         = ~rsel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 2'b00;
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
            wcnt_q <= 4'd0;
            rcnt_q <= 4'd0;
        end else begin
            full_q <= full_d;
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(set_full && clr_full && (wsel_q == rsel_q)));
        end
    end
endmodule

// File: tb/tb_idct_transpose_buf.sv
// Directed and random stimulus for the transpose buffer, checked against a block-FIFO model.
module tb_idct_transpose_buf;
    typedef logic signed [24:0] sample_t;
    typedef sample_t blk_t [16];

    logic clk = 1'b0;
    logic reset;

    idct_transpose_buf_if #(.WIDTH(25)) bus ();

    idct_transpose_buf #(.WIDTH(25), .N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference: completed blocks queue up in arrival order; at most two can be held.
    blk_t    full_blks[$];
    blk_t    cur;
    int      cur_n;
    int      rd_idx;
    logic    wr_hs, rd_hs;
    sample_t obs_q[$];
    logic    last_q[$];
    sample_t wq[$];
    sample_t stim[128];

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        full_blks.delete();
        cur_n  = 0;
        rd_idx = 0;
    endfunction

    function automatic int tpos(input int k);
        return (k % 4) * 4 + k / 4;
    endfunction

    task automatic cycle(input logic iv, input sample_t d, input logic ordy, input logic rst_in);
        logic e_ir, e_ov;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        reset         = rst_in;
        e_ir = (full_blks.size() < 2);
        e_ov = (full_blks.size() > 0);
        check("in_ready", bus.in_ready, e_ir);
        check("out_valid", bus.out_valid, e_ov);
        check("out_last", bus.out_last, e_ov && (rd_idx == 15));
        if (e_ov) check("out_data", bus.out_data, full_blks[0][tpos(rd_idx)]);
        wr_hs = iv && e_ir && !rst_in;
        rd_hs = e_ov && ordy && !rst_in;
        if (rd_hs) begin
            obs_q.push_back(bus.out_data);
            last_q.push_back(bus.out_last);
        end
        if (wr_hs) wq.push_back(d);
        @(posedge clk);
        if (rst_in) begin
            model_reset();
        end else begin
            if (rd_hs) begin
                rd_idx++;
                if (rd_idx == 16) begin
                    void'(full_blks.pop_front());
                    rd_idx = 0;
                end
            end
            if (wr_hs) begin
                cur[cur_n] = d;
                cur_n++;
                if (cur_n == 16) begin
                    full_blks.push_back(cur);
                    cur_n = 0;
                end
            end
        end
        #1;
    endtask

    task automatic clear_capture();
        obs_q.delete();
        last_q.delete();
        wq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, stalls, bubbles, nblk;
        logic    prev_stall;
        sample_t prev_data;
        logic    prev_last;
        logic    iv, ordy;
        sample_t d;

        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_data", bus.out_data, 0);

        // Two blocks back-to-back; the second block's last write meets the first's last read.
        clear_capture();
        first = -1;
        for (int i = 0; i < 32; i++) begin
            if (bus.out_valid && first < 0) first = i;
            cycle(1'b1, sample_t'(i), 1'b1, 1'b0);
        end
        check("first_out_cycle", first, 16);
        check("pp_full", dut.full_q, 2'b10);
        check("pp_wsel", dut.wsel_q, 0);
        check("pp_rsel", dut.rsel_q, 1);
        for (int i = 0; i < 18; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("t1_count", obs_q.size(), 32);
        for (int i = 0; i < 16; i++) check("t1_order", obs_q[i], (i % 4) * 4 + i / 4);
        check("t1_last15", last_q[15], 1);
        check("t1_last14", last_q[14], 0);

        // Both banks full, then release.
        cycle(1'b0, '0, 1'b0, 1'b1);
        clear_capture();
        for (int i = 0; i < 16; i++) cycle(1'b1, sample_t'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b1, sample_t'(200 + i), 1'b0, 1'b0);
        check("hold_in_ready", bus.in_ready, 0);
        cycle(1'b1, sample_t'(300), 1'b0, 1'b0);
        cycle(1'b1, sample_t'(300), 1'b0, 1'b0);
        check("hold_wq", wq.size(), 32);
        for (int i = 0; i < 16; i++) cycle(1'b1, sample_t'(300), 1'b1, 1'b0);
        check("ir_rise", bus.in_ready, 1);
        for (int i = 0; i < 16; i++) cycle(1'b1, sample_t'(300 + i), 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("t3_count", obs_q.size(), 48);
        for (int i = 0; i < 48; i++)
            check("t3_order", obs_q[i], (i / 16 + 1) * 100 + tpos(i % 16));

        // Continuous streaming of full-range signed data.
        cycle(1'b0, '0, 1'b0, 1'b1);
        clear_capture();
        for (int i = 0; i < 128; i++) stim[i] = sample_t'($urandom());
        stim[3]  = -(sample_t'(1) <<< 24);
        stim[20] = (sample_t'(1) <<< 24) - 1;
        stalls = 0;
        bubbles = 0;
        for (int i = 0; i < 144; i++) begin
            if (i < 128 && !bus.in_ready) stalls++;
            if (i >= 16 && !bus.out_valid) bubbles++;
            cycle(i < 128, (i < 128) ? stim[i] : '0, 1'b1, 1'b0);
        end
        check("stream_stalls", stalls, 0);
        check("stream_bubbles", bubbles, 0);
        check("stream_count", obs_q.size(), 128);
        for (int i = 0; i < 128; i++)
            check("stream_data", obs_q[i], stim[(i / 16) * 16 + tpos(i % 16)]);

        // Random valid/ready with stall stability checks.
        cycle(1'b0, '0, 1'b0, 1'b1);
        clear_capture();
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (prev_stall) begin
                check("stall_data", bus.out_data, prev_data);
                check("stall_last", bus.out_last, prev_last);
            end
            iv   = 1'($urandom_range(0, 3) != 0);
            ordy = 1'($urandom_range(0, 1));
            d    = sample_t'($urandom());
            prev_stall = bus.out_valid && !ordy;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            cycle(iv, d, ordy, 1'b0);
        end
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        nblk = wq.size() / 16;
        check("rand_count", obs_q.size(), nblk * 16);
        for (int i = 0; i < obs_q.size() && i < nblk * 16; i++)
            check("rand_data", obs_q[i], wq[(i / 16) * 16 + tpos(i % 16)]);

        // Reset mid-block discards the partial block and the same-cycle write.
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b1, sample_t'(50 + i), 1'b1, 1'b0);
        cycle(1'b1, sample_t'(99), 1'b1, 1'b1);
        clear_capture();
        for (int i = 0; i < 16; i++) begin
            check("mid_rst_no_out", bus.out_valid, 0);
            cycle(1'b1, sample_t'(i), 1'b1, 1'b0);
        end
        check("mid_rst_out_valid", bus.out_valid, 1);
        for (int i = 0; i < 17; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("mid_rst_count", obs_q.size(), 16);
        for (int i = 0; i < obs_q.size() && i < 16; i++)
            check("mid_rst_data", obs_q[i], tpos(i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/idct_transpose_buf.md
# idct_transpose_buf

Ping-pong 4x4 transpose buffer between the row pass and the column pass of the 4-point IDCT. Row-pass results arrive one signed 25-bit sample per cycle in row-major order. They leave one per cycle in column-major order, feeding the column-pass MAC chain. Two banks allow one block to be written while the previous block is drained, so sustained throughput is one sample per cycle.

## Interface
- `WIDTH`, default 25: sample width, signed two's complement.
- `N`, default 4: block dimension; a block holds N*N = 16 samples.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `in_valid`  in  1: `in_data` is valid this cycle.
- `in_ready`  out  1: the buffer accepts a write this cycle.
- `in_data`  in  WIDTH: row-major sample, signed.
- `out_valid`  out  1: `out_data` is valid this cycle.
- `out_ready`  in  1: downstream accepts `out_data` this cycle.
- `out_data`  out  WIDTH: column-major sample, signed.
- `out_last`  out  1: high with the 16th sample of a block.

## Operation
- Storage is two banks, each N*N words of WIDTH bits. Each bank has a 1-bit `full` flag.
- The write side holds a bank select `wsel` and a 4-bit counter `wcnt`.
- The read side holds a bank select `rsel` and a 4-bit counter `rcnt`.
- A write handshake is `in_valid & in_ready`.
  - It stores `in_data` into bank `wsel` at address `wcnt`; address bits are {row[3:2], col[1:0]}.
  - It then increments `wcnt`.
- When `wcnt` = 15 and a write occurs:
  - `full[wsel]` is set.
  - `wsel` toggles.
  - `wcnt` wraps to 0.
- `in_ready` = `!full[wsel]`. It is combinational from registered state and does not depend on `in_valid`.
- `out_valid` = `full[rsel]`.
- `out_data` is the word of bank `rsel` at address {row = `rcnt[1:0]`, col = `rcnt[3:2]`}, which gives column-major order. It is a combinational mux of registered storage, with no arithmetic and no width change.
- A read handshake is `out_valid & out_ready`; it increments `rcnt`.
- When `rcnt` = 15 and a read occurs:
  - `full[rsel]` is cleared.
  - `rsel` toggles.
  - `rcnt` wraps to 0.
- `out_last` = `out_valid & (rcnt == 15)`.
- Block state per bank:
  - FILLING: write side owns the bank.
  - FULL: read side owns the bank.
  - FILLING again after the read side releases it.
- `wsel` and `rsel` each advance strictly in the order 0, 1, 0, 1, ...

## Timing
- Reset values:
  - `full` = 00, `wsel` = `rsel` = 0, `wcnt` = `rcnt` = 0, all storage words = 0.
  - Outputs after reset: `in_ready` = 1, `out_valid` = 0, `out_last` = 0, `out_data` = 0.
- Latency:
  - The first column-major sample appears the cycle after the 16th write of a block.
  - Minimum input-to-output latency is 16 cycles.
- Throughput: with `in_valid` and `out_ready` held high, the input never stalls and the output streams continuously after the first block.
- Both banks FULL: `in_ready` = 0 and `in_data` is ignored. `in_ready` returns to 1 the cycle after the read side completes its 16th read.
- Both banks empty: `out_valid` = 0 and `out_ready` is ignored.
- Simultaneous events in one cycle:
  - The write side may set `full` of one bank while the read side clears `full` of the other. Both updates take effect.
  - Setting and clearing the same bank in one cycle is impossible by construction. It is to be covered by an assertion.
- Stall: while `out_valid & !out_ready`, `out_data` and `out_last` hold stable.
- `reset` asserted mid-block discards all partial and full blocks. State returns to reset values on the next edge, and any handshake in that same cycle is dropped.

## Structure
- Shared IDCT package holds:
  - sample width constant (25);
  - block dimension constant (4);
  - the row-major and column-major address helper functions, reused by the output collector.
- One sub-module, `tbuf_bank`, is natural. It is a single N*N register array with a synchronous write port, a combinational read port and synchronous reset clear. It is instantiated twice.

## Test plan
- Reset, then write samples 0..15 back-to-back with `out_ready` = 1 -> output stream is 0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15, with `out_last` on 15. The first output is the cycle after the 16th write.
- Three blocks with `out_ready` = 0:
  - Block A is values 100..115; block B is values 200..215.
  - After 32 writes `in_ready` = 0 and the 33rd write is held.
  - Raise `out_ready` -> A is read transposed, and `in_ready` rises the cycle after A's 16th read.
- Continuous streaming of 8 blocks of signed values spanning -2^24..2^24-1 -> no input stall, no output bubble after the first block, every sample transposed bit-exact.
- Random `out_ready` toggling -> `out_data` stays stable during stalls and no sample is lost or duplicated; compare against a scoreboard.
- Assert `reset` after 7 writes of a block, then write a fresh 0..15 -> `out_valid` stays 0 until the fresh block completes, and the output is exactly the transpose of 0..15.
- Write the last word of bank 1 in the same cycle as the last read of bank 0 -> `full` = 10 the next cycle, with `wsel` = 0 and `rsel` = 1.
